// File: rtl/parity_writeback_pkg.sv
// Shared CAPI types and constants for the parity write-back engine.
package parity_writeback_pkg;

    localparam logic [11:0] WRITE_NA        = 12'h0D00;
    localparam logic [7:0]  RESP_DONE       = 8'h00;
    localparam logic [7:0]  WED_TAG         = 8'hFF;
    localparam int          CACHELINE_BYTES = 128;

    typedef logic [63:0] pointer_t;

    typedef struct packed {
        logic [7:0] room;
    } CommandInterfaceInput;

    typedef struct packed {
        logic        valid;
        logic [11:0] command;
        logic        command_parity;
        logic [7:0]  tag;
        logic        tag_parity;
        logic [2:0]  abt;
        pointer_t    address;
        logic        address_parity;
        logic [15:0] context_handle;
        logic [11:0] size;
    } CommandInterfaceOutput;

    typedef struct packed {
        logic       read_valid;
        logic [7:0] read_tag;
        logic [5:0] read_address;
    } BufferInterfaceInput;

    typedef struct packed {
        logic [3:0]   read_latency;
        logic [0:511] read_data;
        logic [0:7]   read_parity;
    } BufferInterfaceOutput;

    typedef struct packed {
        logic       valid;
        logic [7:0] tag;
        logic [7:0] response;
    } ResponseInterface;

    // Engine state, also exported on debug_state.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } wb_state_t;

    // Per-slot lifecycle: free -> pending issue -> in flight -> free.
    typedef enum logic [1:0] {
        SLOT_FREE     = 2'd0,
        SLOT_PENDING  = 2'd1,
        SLOT_INFLIGHT = 2'd2
    } slot_state_t;

endpackage

// File: rtl/parity_writeback_line_buffer.sv
// Cacheline storage for in-flight writes with a registered half-line
// read port; odd parity per doubleword is generated on the read path.
module parity_line_buffer
    import parity_writeback_pkg::*;
#(
    parameter int SLOTS  = 4,
    parameter int SLOT_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write_en,
    input  logic [SLOT_W-1:0] write_slot,
    input  logic [0:1023]     write_data,
    input  logic              read_en,
    input  logic              read_hit,
    input  logic [SLOT_W-1:0] read_slot,
    input  logic              read_half,
    output logic [0:511]      read_data,
    output logic [0:7]        read_parity
);

    logic [0:1023] mem [SLOTS];
    logic [0:511]  half_sel;
    logic [0:7]    half_par;

    // Line storage; contents only matter while the slot is occupied.
    always_ff @(posedge clock) begin
        if (write_en) mem[write_slot] <= write_data;
    end

    // Select the requested half (zeros on a miss) and compute odd parity.
    always_comb begin
        half_sel = '0;
        if (read_hit) half_sel = read_half ? mem[read_slot][512:1023] : mem[read_slot][0:511];
        half_par = '0;
        for (int i = 0; i < 8; i++) half_par[i] = ~^half_sel[64*i +: 64];
    end

    // Registered read port: data appears the cycle after the request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_data   <= '0;
            read_parity <= '0;
        end else if (read_en) begin
            read_data   <= half_sel;
            read_parity <= half_par;
        end
    end

endmodule

// File: rtl/parity_writeback.sv
// Write side of the parity AFU: buffers finished cachelines, issues
// Write_na commands under PSL credit control, serves buffer reads and
// retires tags on their responses.
module parity_writeback
    import parity_writeback_pkg::*;
#(
    parameter int         SLOTS        = 4,
    parameter logic [7:0] TAG_BASE     = 8'h00,
    parameter logic [3:0] READ_LATENCY = 4'd1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  pointer_t              dest_addr,
    input  logic [31:0]           line_count,
    input  logic                  line_valid,
    output logic                  line_ready,
    input  logic [0:1023]         line_data,
    input  CommandInterfaceInput  command_in,
    output CommandInterfaceOutput command_out,
    input  BufferInterfaceInput   buffer_in,
    output BufferInterfaceOutput  buffer_out,
    input  ResponseInterface      response,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output wb_state_t             debug_state
);

    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    typedef logic [SLOT_W-1:0] slot_idx_t;
    typedef logic [SLOT_W:0]   cnt_t;

    wb_state_t   state;
    slot_state_t slot_state [SLOTS];
    slot_idx_t   order_q [SLOTS];   // slots awaiting issue, in accept order
    slot_idx_t   q_head, q_tail;
    cnt_t        q_count;
    logic [8:0]  credits;
    logic [31:0] accepted, total;
    pointer_t    next_addr;
    logic        cmd_valid;
    logic [11:0] cmd_command;
    logic [7:0]  cmd_tag;
    pointer_t    cmd_addr;

    logic        active, free_any, accept, issue, resp_hit, read_hit, all_free_next;
    slot_idx_t   free_idx, issue_slot, resp_slot, read_slot;
    cnt_t        used_cnt;
    logic [7:0]  resp_off, read_off;
    logic [0:511] lb_data;
    logic [0:7]   lb_parity;
    logic        unused_read_addr;

    function automatic slot_idx_t wrap_inc(input slot_idx_t p);
        return (32'(p) == SLOTS - 1) ? '0 : p + slot_idx_t'(1);
    endfunction

    // Lowest free slot and occupancy count.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        used_cnt = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (slot_state[i] == SLOT_FREE) begin
                free_any = 1'b1;
                free_idx = slot_idx_t'(i);
            end else begin
                used_cnt = used_cnt + cnt_t'(1);
            end
        end
    end

    assign active     = (state == ST_RUN) || (state == ST_DRAIN);
    assign line_ready = (state == ST_RUN) && free_any && (accepted < total);
    assign accept     = line_valid && line_ready;
    assign issue_slot = order_q[q_head];
    assign issue      = active && (q_count != '0) && (credits != 9'd0);

    // Tags outside TAG_BASE..TAG_BASE+SLOTS-1 (e.g. the WED read) are not ours.
    assign resp_off  = response.tag - TAG_BASE;
    assign resp_slot = resp_off[SLOT_W-1:0];
    assign resp_hit  = active && response.valid && (response.tag != WED_TAG) &&
                       (resp_off < 8'(SLOTS)) && (slot_state[resp_slot] == SLOT_INFLIGHT);
    assign read_off  = buffer_in.read_tag - TAG_BASE;
    assign read_slot = read_off[SLOT_W-1:0];
    assign read_hit  = (buffer_in.read_tag != WED_TAG) && (read_off < 8'(SLOTS)) &&
                       (slot_state[read_slot] == SLOT_INFLIGHT);
    // Only address bit 5 (which half) matters for a 128-byte line.
    assign unused_read_addr = ^buffer_in.read_address[4:0];

    // Draining finishes once nothing is pending or in flight after this edge.
    assign all_free_next = (used_cnt == '0) || ((used_cnt == cnt_t'(1)) && resp_hit);

    // Control FSM with slot bookkeeping, credits and the registered command.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            credits     <= '0;
            accepted    <= '0;
            total       <= '0;
            next_addr   <= '0;
            cmd_valid   <= 1'b0;
            cmd_command <= '0;
            cmd_tag     <= '0;
            cmd_addr    <= '0;
            q_head      <= '0;
            q_tail      <= '0;
            q_count     <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_state[i] <= SLOT_FREE;
                order_q[i]    <= '0;
            end
        end else begin
            cmd_valid <= 1'b0;
            if (start && !active) begin
                credits   <= {1'b0, command_in.room};
                accepted  <= '0;
                total     <= line_count;
                next_addr <= dest_addr;
                error     <= 1'b0;
                done      <= (line_count == 32'd0);
                busy      <= (line_count != 32'd0);
                state     <= (line_count == 32'd0) ? ST_DONE : ST_RUN;
                q_head    <= '0;
                q_tail    <= '0;
                q_count   <= '0;
                for (int i = 0; i < SLOTS; i++) slot_state[i] <= SLOT_FREE;
            end else if (active) begin
                if (accept) begin
                    slot_state[free_idx] <= SLOT_PENDING;
                    order_q[q_tail]      <= free_idx;
                    q_tail               <= wrap_inc(q_tail);
                    accepted             <= accepted + 32'd1;
                end
                if (issue) begin
                    slot_state[issue_slot] <= SLOT_INFLIGHT;
                    q_head                 <= wrap_inc(q_head);
                    cmd_valid              <= 1'b1;
                    cmd_command            <= WRITE_NA;
                    cmd_tag                <= TAG_BASE + 8'(issue_slot);
                    cmd_addr               <= next_addr;
                    next_addr              <= next_addr + 64'(CACHELINE_BYTES);
                end
                if (resp_hit) slot_state[resp_slot] <= SLOT_FREE;
                case ({accept, issue})
                    2'b10:   q_count <= q_count + cnt_t'(1);
                    2'b01:   q_count <= q_count - cnt_t'(1);
                    default: q_count <= q_count;
                endcase
                case ({resp_hit, issue})
                    2'b10:   credits <= credits + 9'd1;
                    2'b01:   credits <= credits - 9'd1;
                    default: credits <= credits;
                endcase
                if (resp_hit && (response.response != RESP_DONE)) begin
                    state <= ST_ERROR;
                    error <= 1'b1;
                    busy  <= 1'b0;
                end else if ((state == ST_RUN) && accept && (accepted + 32'd1 == total)) begin
                    state <= ST_DRAIN;
                end else if ((state == ST_DRAIN) && all_free_next) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
            end
        end
    end

    parity_line_buffer #(.SLOTS(SLOTS), .SLOT_W(SLOT_W)) u_line_buffer (
        .clock       (clock),
        .reset       (reset),
        .write_en    (accept),
        .write_slot  (free_idx),
        .write_data  (line_data),
        .read_en     (buffer_in.read_valid),
        .read_hit    (read_hit),
        .read_slot   (read_slot),
        .read_half   (buffer_in.read_address[5]),
        .read_data   (lb_data),
        .read_parity (lb_parity)
    );

    // Command and buffer interface assembly; parities are odd and combinational.
    always_comb begin
        command_out                = '0;
        command_out.valid          = cmd_valid;
        command_out.command        = cmd_command;
        command_out.command_parity = ~^cmd_command;
        command_out.tag            = cmd_tag;
        command_out.tag_parity     = ~^cmd_tag;
        command_out.abt            = 3'd0;
        command_out.address        = cmd_addr;
        command_out.address_parity = ~^cmd_addr;
        command_out.context_handle = 16'd0;
        command_out.size           = 12'(CACHELINE_BYTES);
        buffer_out                 = '0;
        buffer_out.read_latency    = READ_LATENCY;
        buffer_out.read_data       = lb_data;
        buffer_out.read_parity     = lb_parity;
    end

    assign debug_state = state;

endmodule

// File: tb/tb_parity_writeback.sv
// Directed bench for parity_writeback with a queue-based scoreboard:
// expected commands and read returns are queued when stimulus is issued
// and a negedge monitor pops and compares whenever the DUT presents them.
module tb_parity_writeback;
    import parity_writeback_pkg::*;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    pointer_t              dest_addr = '0;
    logic [31:0]           line_count = '0;
    logic                  line_valid = 1'b0;
    logic                  line_ready;
    logic [0:1023]         line_data = '0;
    CommandInterfaceInput  command_in = '0;
    CommandInterfaceOutput command_out;
    BufferInterfaceInput   buffer_in = '0;
    BufferInterfaceOutput  buffer_out;
    ResponseInterface      response = '0;
    logic                  busy, done, error;
    wb_state_t             debug_state;

    int checks = 0;
    int errors = 0;
    int cmds_seen = 0;
    int base;
    logic rd_due = 1'b0;
    logic ready_low;
    logic [71:0]  cmd_exp_q[$];   // {tag, address}
    logic [519:0] rd_exp_q[$];    // {read_data, read_parity}
    logic [71:0]  cmd_exp;
    logic [519:0] rd_exp;

    parity_writeback dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dest_addr   (dest_addr),
        .line_count  (line_count),
        .line_valid  (line_valid),
        .line_ready  (line_ready),
        .line_data   (line_data),
        .command_in  (command_in),
        .command_out (command_out),
        .buffer_in   (buffer_in),
        .buffer_out  (buffer_out),
        .response    (response),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .debug_state (debug_state)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [511:0] actual, input logic [511:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic odd_par(input logic [63:0] v);
        int ones = 0;
        for (int i = 0; i < 64; i++) ones += int'(v[i]);
        return (ones % 2) == 0;
    endfunction

    function automatic logic [0:7] exp_parity(input logic [0:511] d);
        logic [0:7] p;
        for (int i = 0; i < 8; i++) p[i] = odd_par(d[64*i +: 64]);
        return p;
    endfunction

    // Byte b of the line holds seed+b.
    function automatic logic [0:1023] make_line(input logic [7:0] seed);
        logic [0:1023] l;
        for (int b = 0; b < 128; b++) l[8*b +: 8] = seed + 8'(b);
        return l;
    endfunction

    // Monitor: command issue and read-return scoreboard.
    always @(negedge clock) begin
        if (!reset && command_out.valid) begin
            if (cmd_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd: got tag %0h addr %0h, expected no command",
                         command_out.tag, command_out.address);
            end else begin
                cmd_exp = cmd_exp_q.pop_front();
                check("cmd_tag", 512'(command_out.tag), 512'(cmd_exp[71:64]));
                check("cmd_address", 512'(command_out.address), 512'(cmd_exp[63:0]));
                check("cmd_opcode", 512'(command_out.command), 512'(12'h0D00));
                check("cmd_size", 512'(command_out.size), 512'(12'd128));
                check("cmd_parity", 512'(command_out.command_parity), 512'(odd_par(64'h0D00)));
                check("tag_parity", 512'(command_out.tag_parity), 512'(odd_par(64'(cmd_exp[71:64]))));
                check("addr_parity", 512'(command_out.address_parity), 512'(odd_par(cmd_exp[63:0])));
            end
            cmds_seen++;
        end
        if (rd_due) begin
            if (rd_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_scoreboard: got a read return, expected none queued");
            end else begin
                rd_exp = rd_exp_q.pop_front();
                check("read_data", 512'(buffer_out.read_data), rd_exp[519:8]);
                check("read_parity", 512'(buffer_out.read_parity), 512'(rd_exp[7:0]));
            end
        end
        rd_due = buffer_in.read_valid;
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] tag, input logic [63:0] addr);
        cmd_exp_q.push_back({tag, addr});
    endtask

    task automatic do_start(input logic [63:0] addr, input logic [31:0] cnt, input logic [7:0] room);
        sync();
        start = 1'b1;
        dest_addr = addr;
        line_count = cnt;
        command_in.room = room;
        sync();
        start = 1'b0;
    endtask

    // Caller must be at posedge+1; returns at posedge+1 after the handshake.
    task automatic send_line(input logic [0:1023] l);
        int waited = 0;
        line_valid = 1'b1;
        line_data = l;
        while (waited < 300) begin
            @(negedge clock);
            if (line_ready) break;
            waited++;
        end
        if (waited >= 300) begin
            checks++;
            errors++;
            $display("FAIL line_accept_timeout: got no line_ready, expected acceptance");
        end
        sync();
        line_valid = 1'b0;
    endtask

    task automatic respond(input logic [7:0] tag, input logic [7:0] code);
        sync();
        response.valid = 1'b1;
        response.tag = tag;
        response.response = code;
        sync();
        response.valid = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] tag, input logic half, input logic [0:1023] l, input logic known);
        logic [0:511] d;
        d = '0;
        if (known) d = half ? l[512:1023] : l[0:511];
        rd_exp_q.push_back({d, exp_parity(d)});
        sync();
        buffer_in.read_valid = 1'b1;
        buffer_in.read_tag = tag;
        buffer_in.read_address = {half, 5'b0};
        sync();
        buffer_in.read_valid = 1'b0;
    endtask

    task automatic wait_cmds(input int n);
        int w = 0;
        while (cmds_seen < n && w < 300) begin
            @(negedge clock);
            w++;
        end
        check("cmd_count_reached", 512'(cmds_seen), 512'(n));
    endtask

    task automatic wait_done(input int max_cycles);
        int w = 0;
        while (done !== 1'b1 && w < max_cycles) begin
            @(negedge clock);
            w++;
        end
        check("done_asserted", 512'(done), 512'(1'b1));
    endtask

    initial begin
        // Reset values while reset is held.
        repeat (2) @(negedge clock);
        check("rst_cmd_valid", 512'(command_out.valid), 512'(1'b0));
        check("rst_cmd_opcode", 512'(command_out.command), 512'(12'h000));
        check("rst_cmd_tag", 512'(command_out.tag), 512'(8'h00));
        check("rst_cmd_address", 512'(command_out.address), 512'(64'h0));
        check("rst_cmd_size", 512'(command_out.size), 512'(12'd128));
        check("rst_read_data", 512'(buffer_out.read_data), 512'(0));
        check("rst_read_parity", 512'(buffer_out.read_parity), 512'(8'h00));
        check("rst_read_latency", 512'(buffer_out.read_latency), 512'(4'd1));
        check("rst_line_ready", 512'(line_ready), 512'(1'b0));
        check("rst_flags", 512'({busy, done, error}), 512'(3'b000));
        check("rst_state", 512'(debug_state), 512'(ST_IDLE));
        sync();
        reset = 1'b0;

        // Single line: one Write_na, both halves read back, DONE response.
        base = cmds_seen;
        push_cmd(8'h00, 64'h1000);
        do_start(64'h1000, 32'd1, 8'd8);
        @(negedge clock);
        check("t1_busy", 512'(busy), 512'(1'b1));
        check("t1_state_run", 512'(debug_state), 512'(ST_RUN));
        sync();
        send_line(make_line(8'h40));
        wait_cmds(base + 1);
        do_read(8'h00, 1'b0, make_line(8'h40), 1'b1);
        do_read(8'h00, 1'b1, make_line(8'h40), 1'b1);
        respond(8'h00, 8'h00);
        wait_done(3);
        check("t1_state_done", 512'(debug_state), 512'(ST_DONE));
        check("t1_busy_low", 512'(busy), 512'(1'b0));

        // Six lines through four slots: stall until a response frees a slot.
        base = cmds_seen;
        for (int k = 0; k < 6; k++) push_cmd(8'(k % 4), 64'h1000 + 64'(k * 128));
        do_start(64'h1000, 32'd6, 8'd8);
        check("t2_done_cleared", 512'(done), 512'(1'b0));
        fork
            begin
                for (int k = 0; k < 6; k++) send_line(make_line(8'h10 + 8'(k)));
            end
            begin
                wait_cmds(base + 4);
                ready_low = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clock);
                    if (line_ready) ready_low = 1'b0;
                end
                check("t2_full_line_ready_low", 512'(ready_low), 512'(1'b1));
                respond(8'h00, 8'h00);
                wait_cmds(base + 5);
                do_read(8'h00, 1'b1, make_line(8'h14), 1'b1);
                respond(8'h01, 8'h00);
                wait_cmds(base + 6);
                respond(8'h02, 8'h00);
                respond(8'h03, 8'h00);
                respond(8'h00, 8'h00);
                respond(8'h01, 8'h00);
            end
        join
        wait_done(5);
        check("t2_state_done", 512'(debug_state), 512'(ST_DONE));

        // One credit: commands strictly one at a time, in accept order.
        base = cmds_seen;
        for (int k = 0; k < 3; k++) push_cmd(8'(k), 64'h2000 + 64'(k * 128));
        do_start(64'h2000, 32'd3, 8'd1);
        fork
            begin
                for (int k = 0; k < 3; k++) send_line(make_line(8'h80 + 8'(k)));
            end
            begin
                wait_cmds(base + 1);
                repeat (4) @(negedge clock);
                check("t3_one_inflight_a", 512'(cmds_seen), 512'(base + 1));
                do_read(8'h05, 1'b0, '0, 1'b0);
                respond(8'h00, 8'h00);
                wait_cmds(base + 2);
                repeat (3) @(negedge clock);
                check("t3_one_inflight_b", 512'(cmds_seen), 512'(base + 2));
                respond(8'h01, 8'h00);
                wait_cmds(base + 3);
                respond(8'h02, 8'h00);
            end
        join
        wait_done(5);

        // Error response on tag 2, then a zero-length start clears it.
        base = cmds_seen;
        for (int k = 0; k < 4; k++) push_cmd(8'(k), 64'h3000 + 64'(k * 128));
        do_start(64'h3000, 32'd4, 8'd8);
        for (int k = 0; k < 4; k++) send_line(make_line(8'hC0 + 8'(k)));
        wait_cmds(base + 4);
        respond(8'h02, 8'h01);
        @(negedge clock);
        check("t4_error_set", 512'(error), 512'(1'b1));
        check("t4_done_low", 512'(done), 512'(1'b0));
        check("t4_state_error", 512'(debug_state), 512'(ST_ERROR));
        check("t4_busy_low", 512'(busy), 512'(1'b0));
        base = cmds_seen;
        do_start(64'h5000, 32'd0, 8'd8);
        @(negedge clock);
        check("t5_done_next_cycle", 512'(done), 512'(1'b1));
        check("t5_error_cleared", 512'(error), 512'(1'b0));
        check("t5_state_done", 512'(debug_state), 512'(ST_DONE));
        repeat (5) @(negedge clock);
        check("t5_no_command", 512'(cmds_seen), 512'(base));

        // Reset during DRAIN with three writes in flight.
        sync();
        base = cmds_seen;
        for (int k = 0; k < 3; k++) push_cmd(8'(k), 64'h4000 + 64'(k * 128));
        do_start(64'h4000, 32'd3, 8'd8);
        for (int k = 0; k < 3; k++) send_line(make_line(8'hE0 + 8'(k)));
        wait_cmds(base + 3);
        check("t6_state_drain", 512'(debug_state), 512'(ST_DRAIN));
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_state", 512'(debug_state), 512'(ST_IDLE));
        check("t6_async_busy", 512'(busy), 512'(1'b0));
        check("t6_async_cmd_addr", 512'(command_out.address), 512'(64'h0));
        check("t6_async_cmd_tag", 512'(command_out.tag), 512'(8'h00));
        check("t6_async_line_ready", 512'(line_ready), 512'(1'b0));
        sync();
        reset = 1'b0;
        respond(8'h01, 8'h01);
        @(negedge clock);
        check("t6_late_resp_error", 512'(error), 512'(1'b0));
        check("t6_late_resp_state", 512'(debug_state), 512'(ST_IDLE));
        sync();
        do_read(8'h01, 1'b0, '0, 1'b0);

        repeat (4) @(negedge clock);
        check("cmd_queue_empty", 512'(cmd_exp_q.size()), 512'(0));
        check("read_queue_empty", 512'(rd_exp_q.size()), 512'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
